eqn_serial_cmp_amisha: RTL and testbench
========================================

# eqn_serial_cmp_amisha

Parametrised, bit-serial magnitude/equality comparator that generalises the single-bit equality gate to WIDTH-bit operands with selectable slice width and signed/unsigned mode. It captures two operands on a start handshake and scans them MSB-slice-first, one slice per clock. It terminates early on the first differing slice and reports a registered eq/gt/lt result with a one-cycle done pulse. It sits beside the combinational comparators as the area-lean option for wide operands.

## Interface
- WIDTH, 8: operand width in bits; ≥ 2.
- SLICE, 1: bits compared per cycle; must divide WIDTH. N = WIDTH/SLICE slices.
- SIGNED_MODE, 0: 0 = unsigned compare, 1 = two's-complement compare.
- clk_amisha  in  1  clock; all state changes on rising edge.
- rst_n_amisha  in  1  asynchronous, active-low reset.
- start_amisha  in  1  request; accepted when start_amisha && ready_amisha at a rising edge.
- a_amisha  in  WIDTH  operand A; sampled only at accept.
- b_amisha  in  WIDTH  operand B; sampled only at accept.
- ready_amisha  out  1  high in IDLE and DONE, low in SCAN.
- done_amisha  out  1  one-cycle pulse; result valid.
- eq_amisha  out  1  A == B.
- gt_amisha  out  1  A > B.
- lt_amisha  out  1  A < B.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: accept → capture a/b, slice index k = N-1 (MSB slice), go to SCAN.
- SCAN: compare slice k of A vs B.
  - If the slices differ, register gt/lt from that slice and go to DONE.
  - If equal and k = 0, register eq and go to DONE.
  - Otherwise k ← k-1.
- SIGNED_MODE=1: invert bit WIDTH-1 of both operands before comparing the MSB slice. Lower slices compare unsigned.
- DONE: done_amisha=1 for exactly one cycle.
  - Accept in DONE → capture and go to SCAN (back-to-back).
  - No accept → go to IDLE.
- Result flags hold until the next DONE. After the first DONE, exactly one of eq/gt/lt is 1.
- start_amisha in SCAN is ignored; a/b changes in SCAN have no effect.

## Timing
- Reset (asserted at any time, including mid-SCAN):
  - State IDLE immediately.
  - ready_amisha=1; done/eq/gt/lt=0.
  - Any in-flight compare is discarded; no done pulse.
- Accept at edge E0. Mismatch in slice position j (0 = MSB slice): done_amisha high from edge E(j+1) to E(j+2).
- Equal operands: done_amisha high from E(N) to E(N+1). Worst-case latency is N cycles; best case is 1.
- Result flags update at the same edge done_amisha rises.
- Throughput, back-to-back in DONE: one compare per (latency+1) cycles, with no IDLE gap.

## Structure
- Package eqn_cmp_pkg_amisha: state enum (IDLE/SCAN/DONE) and result encoding constants (RES_EQ, RES_GT, RES_LT).
- Sub-module eq_slice_amisha: combinational SLICE-bit comparator outputting eq/gt. Instantiated once and muxed by k.
- Top: FSM, operand shift/index registers, result register. Elaborate-time check: WIDTH % SLICE == 0.

## Test plan
- WIDTH=8, SLICE=1, unsigned; a=0xA5, b=0xA5 → done 8 cycles after accept, eq=1, gt=lt=0.
- Same config; a=0x80, b=0x7F → done 1 cycle after accept, gt=1. Then a=0xA4, b=0xA5 → done at cycle 8, lt=1.
- SIGNED_MODE=1; a=0x80, b=0x7F → lt=1 after 1 cycle. a=0xFF, b=0xFE → gt=1 after 8 cycles.
- WIDTH=16, SLICE=4; a=b=0x1234 → eq after 4 cycles. Then a=0x1235, b=0x1234 → gt after 4 cycles.
- start pulsed with new operands mid-SCAN is ignored (original result reported). Start held in DONE cycle → new compare begins with no IDLE cycle.
- rst_n_amisha low at cycle 3 of an 8-cycle compare → all outputs 0 and ready=1 immediately, no done pulse. A fresh compare after release completes normally.

Source files
------------

// File: rtl/eqn_serial_cmp_amisha_pkg.sv
// eqn_cmp_pkg_amisha: shared FSM state type and one-hot result encodings for the serial comparator
package eqn_cmp_pkg_amisha;
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;
    localparam logic [2:0] RES_EQ = 3'b001;
    localparam logic [2:0] RES_GT = 3'b010;
    localparam logic [2:0] RES_LT = 3'b100;
endpackage

// File: rtl/eqn_serial_cmp_amisha_slice.sv
// eq_slice_amisha: combinational SLICE-bit unsigned comparator producing equal and greater-than
module eq_slice_amisha #(
    parameter int SLICE = 1
) (
    input  logic [SLICE-1:0] i_a,
    input  logic [SLICE-1:0] i_b,
    output logic             o_eq,
    output logic             o_gt
);
    assign o_eq = i_a == i_b;
    assign o_gt = i_a > i_b;
endmodule

// File: rtl/eqn_serial_cmp_amisha.sv
// eqn_serial_cmp_amisha: bit-serial MSB-slice-first magnitude/equality comparator with early exit
module eqn_serial_cmp_amisha
    import eqn_cmp_pkg_amisha::*;
#(
    parameter int WIDTH       = 8,
    parameter int SLICE       = 1,
    parameter int SIGNED_MODE = 0
) (
    input  logic             clk_amisha,
    input  logic             rst_n_amisha,
    input  logic             start_amisha,
    input  logic [WIDTH-1:0] a_amisha,
    input  logic [WIDTH-1:0] b_amisha,
    output logic             ready_amisha,
    output logic             done_amisha,
    output logic             eq_amisha,
    output logic             gt_amisha,
    output logic             lt_amisha
);
    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(N - 1);
    // Flipping the sign bit of both operands at capture turns a two's-complement
    // compare into an unsigned one, so the slice datapath never needs to know the mode.
    localparam logic [WIDTH-1:0] FLIP = (SIGNED_MODE != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

    if (WIDTH < 2 || WIDTH % SLICE != 0) begin : g_param_err
        $error("eqn_serial_cmp_amisha: WIDTH must be >= 2 and a multiple of SLICE");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [KW-1:0]    r_k;
    logic             r_ready;
    logic             r_done;
    logic [2:0]       r_res;
    logic [SLICE-1:0] w_sa;
    logic [SLICE-1:0] w_sb;
    logic             w_eq;
    logic             w_gt;

    assign w_sa = r_a[r_k*SLICE +: SLICE];
    assign w_sb = r_b[r_k*SLICE +: SLICE];

    eq_slice_amisha #(.SLICE(SLICE)) u_slice (
        .i_a  (w_sa),
        .i_b  (w_sb),
        .o_eq (w_eq),
        .o_gt (w_gt)
    );

    // Control FSM: capture on accept, walk slices from the top, stop on first difference.
    always_ff @(posedge clk_amisha or negedge rst_n_amisha) begin
        if (!rst_n_amisha) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_k     <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_res   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start_amisha) begin
                        r_a     <= a_amisha ^ FLIP;
                        r_b     <= b_amisha ^ FLIP;
                        r_k     <= K_TOP;
                        r_ready <= 1'b0;
                        r_state <= SCAN;
                    end else begin
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                SCAN: begin
                    if (!w_eq || r_k == '0) begin
                        r_res   <= w_eq ? RES_EQ : (w_gt ? RES_GT : RES_LT);
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k - 1'b1;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ready_amisha = r_ready;
    assign done_amisha  = r_done;
    assign eq_amisha    = r_res[0];
    assign gt_amisha    = r_res[1];
    assign lt_amisha    = r_res[2];
endmodule

// File: tb/tb_eqn_serial_cmp_amisha.sv
// tb_eqn_serial_cmp_amisha: scoreboard bench over three comparator configurations
module tb_eqn_serial_cmp_amisha;
    typedef struct {
        int         ch;
        logic [2:0] res;
        int         due;
    } exp_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic [2:0]       st    = '0;
    logic [2:0]       rdy, dn, eq, gt, lt;
    logic [2:0][15:0] a     = '0;
    logic [2:0][15:0] b     = '0;
    int               cyc      = 0;
    int               checks   = 0;
    int               failures = 0;
    exp_t             q[$];
    exp_t             m_e;
    int               m_idx;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eqn_serial_cmp_amisha #(.WIDTH(8), .SLICE(1), .SIGNED_MODE(0)) u0 (
        .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(st[0]),
        .a_amisha(a[0][7:0]), .b_amisha(b[0][7:0]), .ready_amisha(rdy[0]),
        .done_amisha(dn[0]), .eq_amisha(eq[0]), .gt_amisha(gt[0]), .lt_amisha(lt[0]));
    eqn_serial_cmp_amisha #(.WIDTH(8), .SLICE(1), .SIGNED_MODE(1)) u1 (
        .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(st[1]),
        .a_amisha(a[1][7:0]), .b_amisha(b[1][7:0]), .ready_amisha(rdy[1]),
        .done_amisha(dn[1]), .eq_amisha(eq[1]), .gt_amisha(gt[1]), .lt_amisha(lt[1]));
    eqn_serial_cmp_amisha #(.WIDTH(16), .SLICE(4), .SIGNED_MODE(0)) u2 (
        .clk_amisha(clk), .rst_n_amisha(rst_n), .start_amisha(st[2]),
        .a_amisha(a[2]), .b_amisha(b[2]), .ready_amisha(rdy[2]),
        .done_amisha(dn[2]), .eq_amisha(eq[2]), .gt_amisha(gt[2]), .lt_amisha(lt[2]));

    function automatic int cw(int c);
        return (c == 2) ? 16 : 8;
    endfunction

    function automatic int cs(int c);
        return (c == 2) ? 4 : 1;
    endfunction

    // Reference result from plain integer ordering of the operand values.
    function automatic logic [2:0] ref_res(int c, logic [15:0] x, logic [15:0] y);
        longint vx = longint'(x);
        longint vy = longint'(y);
        int     wd = cw(c);
        if (c == 1) begin
            if (x[wd-1]) vx -= longint'(1) << wd;
            if (y[wd-1]) vy -= longint'(1) << wd;
        end
        return (vx == vy) ? 3'b001 : ((vx > vy) ? 3'b010 : 3'b100);
    endfunction

    // Reference latency: 1 + number of leading (MSB-side) slices that agree.
    function automatic int ref_lat(int c, logic [15:0] x, logic [15:0] y);
        int          wd = cw(c);
        int          s  = cs(c);
        logic [15:0] m  = (16'd1 << s) - 16'd1;
        logic [15:0] d  = x ^ y;
        for (int j = 0; j < wd / s; j++)
            if (((d >> (wd - (j + 1) * s)) & m) != 16'd0) return j + 1;
        return wd / s;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_idle_outputs(int c);
        check("reset_ready", int'(rdy[c]), 1);
        check("reset_done", int'(dn[c]), 0);
        check("reset_flags", int'({lt[c], gt[c], eq[c]}), 0);
    endtask

    task automatic issue(int c, logic [15:0] xi, logic [15:0] yi);
        int          w = 0;
        logic [15:0] m = (cw(c) == 16) ? 16'hFFFF : 16'h00FF;
        logic [15:0] x = xi & m;
        logic [15:0] y = yi & m;
        exp_t        e;
        while (!rdy[c] && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!rdy[c]) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout ch=%0d actual=0 required=1", c);
            return;
        end
        a[c]  = x;
        b[c]  = y;
        st[c] = 1'b1;
        e.ch  = c;
        e.res = ref_res(c, x, y);
        e.due = cyc + 1 + ref_lat(c, x, y);
        q.push_back(e);
        @(negedge clk);
        st[c] = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout pending=%0d required=0", q.size());
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request of its channel.
    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (dn[c]) begin
                m_idx = -1;
                foreach (q[i]) if (m_idx < 0 && q[i].ch == c) m_idx = i;
                if (m_idx < 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done ch=%0d actual=1 required=0 (cycle %0d)", c, cyc);
                end else begin
                    m_e = q[m_idx];
                    q.delete(m_idx);
                    check($sformatf("result_ch%0d", c), int'({lt[c], gt[c], eq[c]}), int'(m_e.res));
                    check($sformatf("done_cycle_ch%0d", c), cyc, m_e.due);
                end
            end
        end
    end

    initial begin
        int          w;
        int          c;
        int          mode;
        logic [15:0] x;
        logic [15:0] y;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle_outputs(i);
        rst_n = 1'b1;
        @(negedge clk);

        issue(0, 16'hA5, 16'hA5);
        issue(0, 16'h80, 16'h7F);
        issue(0, 16'hA4, 16'hA5);
        issue(1, 16'h80, 16'h7F);
        issue(1, 16'hFF, 16'hFE);
        issue(2, 16'h1234, 16'h1234);
        issue(2, 16'h1235, 16'h1234);
        drain();

        issue(0, 16'hA5, 16'hA5);
        @(negedge clk);
        check("scan_ready_low", int'(rdy[0]), 0);
        a[0]  = 16'h00;
        b[0]  = 16'hFF;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        drain();

        issue(0, 16'h80, 16'h7F);
        w = 0;
        while (!rdy[0] && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("b2b_done_with_ready", int'(dn[0]), 1);
        issue(0, 16'h3C, 16'h3D);
        drain();

        @(negedge clk);
        a[0]  = 16'hA5;
        b[0]  = 16'hA5;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(0);
        repeat (10) @(negedge clk);
        check_idle_outputs(0);
        rst_n = 1'b1;
        @(negedge clk);
        repeat (10) @(negedge clk);
        issue(0, 16'hA4, 16'hA5);
        issue(2, 16'h8000, 16'h7FFF);
        drain();

        for (int i = 0; i < 60; i++) begin
            c    = int'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 3));
            x    = 16'($urandom);
            y    = (mode == 0) ? x :
                   (mode == 1) ? x ^ (16'd1 << $urandom_range(0, cw(c) - 1)) : 16'($urandom);
            issue(c, x, y);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
